// File: rtl/max7219_word_scheduler_if.sv
// -----------------------------------------------------------------------------
// max7219_word_scheduler_if
//   Byte-wide link between the MAX7219 word scheduler and the shared spi_master.
//   master modport: the scheduler (drives the byte and its start strobe).
//   slave  modport: the spi_master (reports busy and the byte-complete pulse).
//
//   spi_data   8  byte for spi_master data_in
//   spi_start  1  one-cycle start strobe
//   spi_busy   1  spi_master is shifting a byte
//   spi_avail  1  one-cycle pulse: byte shifted out
// -----------------------------------------------------------------------------
interface max7219_word_scheduler_if;
    logic [7:0] spi_data;
    logic       spi_start;
    logic       spi_busy;
    logic       spi_avail;

    modport master (
        output spi_data,
        output spi_start,
        input  spi_busy,
        input  spi_avail
    );

    modport slave (
        input  spi_data,
        input  spi_start,
        output spi_busy,
        output spi_avail
    );
endinterface

// File: rtl/max7219_word_scheduler.sv
// -----------------------------------------------------------------------------
// max7219_word_scheduler
//   Sequences 16-bit MAX7219 register writes (address byte, then data byte) onto
//   a byte-wide spi_master and owns the MAX7219 LOAD/CS pin, keeping it low
//   across both bytes of a word. After reset it runs the 5-word init job, then
//   serves requests from IDLE with priority reinit > intensity > frame.
//
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   frame_req_i   level request: write frame_data_i to digit registers 1..8
//   frame_data_i  row r = bits [8r+7:8r], goes to digit register r+1
//   frame_ack_o   one-cycle pulse: frame captured, frame job entered
//   int_req_i     level request: write the intensity register
//   int_val_i     intensity value, captured at int_ack_o
//   int_ack_o     one-cycle pulse: int_val_i captured
//   reinit_req_i  level request: rerun the init job (no ack)
//   spi           byte link to spi_master (master side)
//   load_n_o      MAX7219 LOAD/CS, active-low; rising edge latches the word
//   ready_o       high only while idle after init has completed
// -----------------------------------------------------------------------------
module max7219_word_scheduler #(
    parameter logic [3:0] INIT_INTENSITY = 4'hA,
    parameter logic [2:0] SCAN_LIMIT     = 3'd7,
    parameter int         LOAD_GAP       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_req_i,
    input  logic [63:0] frame_data_i,
    output logic        frame_ack_o,
    input  logic        int_req_i,
    input  logic [3:0]  int_val_i,
    output logic        int_ack_o,
    input  logic        reinit_req_i,
    max7219_word_scheduler_if.master spi,
    output logic        load_n_o,
    output logic        ready_o
);

    localparam int GAP_W = (LOAD_GAP > 1) ? $clog2(LOAD_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LOAD_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI_WAIT,
        ST_HI_SEND,
        ST_LO_WAIT,
        ST_LO_SEND,
        ST_GAP
    } state_e;

    typedef enum logic [1:0] {
        JOB_INIT,
        JOB_FRAME,
        JOB_INT
    } job_e;

    state_e           state_q, state_d;
    job_e             job_q, job_d;
    logic [2:0]       idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             load_n_q, load_n_d;
    logic             start_q, start_d;
    logic [7:0]       spi_data_q, spi_data_d;

    // Latched request payloads; they only feed the datapath, so no reset.
    logic [63:0]      frame_q;
    logic [3:0]       int_q;
    logic             frame_cap, int_cap;
    logic [15:0]      cur_word;

    function automatic logic [15:0] word_of(input job_e job, input logic [2:0] idx,
                                            input logic [63:0] frame, input logic [3:0] ival);
        logic [15:0] w;
        w = 16'h0000;
        case (job)
            JOB_INIT: begin
                case (idx)
                    3'd0:    w = 16'h0C01;                         // leave shutdown
                    3'd1:    w = 16'h0900;                         // no BCD decode
                    3'd2:    w = {8'h0A, 4'h0, INIT_INTENSITY};
                    3'd3:    w = {8'h0B, 5'b0, SCAN_LIMIT};
                    default: w = 16'h0F00;                         // display test off
                endcase
            end
            JOB_FRAME: w = {({5'd0, idx} + 8'd1), frame[{idx, 3'b000} +: 8]};
            JOB_INT:   w = {8'h0A, 4'h0, ival};
            default:   w = 16'h0000;
        endcase
        return w;
    endfunction

    function automatic logic [2:0] last_idx(input job_e job);
        logic [2:0] l;
        case (job)
            JOB_INIT:  l = 3'd4;
            JOB_FRAME: l = 3'd7;
            default:   l = 3'd0;
        endcase
        return l;
    endfunction

    assign cur_word          = word_of(job_q, idx_q, frame_q, int_q);
    assign spi.spi_data      = spi_data_q;
    assign spi.spi_start     = start_q;
    assign load_n_o          = load_n_q;
    assign ready_o           = (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        job_d       = job_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        load_n_d    = load_n_q;
        start_d     = 1'b0;
        spi_data_d  = spi_data_q;
        frame_ack_o = 1'b0;
        int_ack_o   = 1'b0;
        frame_cap   = 1'b0;
        int_cap     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (reinit_req_i) begin
                    job_d   = JOB_INIT;
                    idx_d   = 3'd0;
                    state_d = ST_HI_WAIT;
                end else if (int_req_i) begin
                    int_ack_o = 1'b1;
                    int_cap   = 1'b1;
                    job_d     = JOB_INT;
                    idx_d     = 3'd0;
                    state_d   = ST_HI_WAIT;
                end else if (frame_req_i) begin
                    frame_ack_o = 1'b1;
                    frame_cap   = 1'b1;
                    job_d       = JOB_FRAME;
                    idx_d       = 3'd0;
                    state_d     = ST_HI_WAIT;
                end
            end
            // Start strobe and LOAD fall are registered together so the pin
            // drops in the same cycle the spi_master sees the address byte.
            ST_HI_WAIT: begin
                spi_data_d = cur_word[15:8];
                if (!spi.spi_busy) begin
                    start_d  = 1'b1;
                    load_n_d = 1'b0;
                    state_d  = ST_HI_SEND;
                end
            end
            ST_HI_SEND: begin
                if (spi.spi_avail) begin
                    state_d = ST_LO_WAIT;
                end
            end
            ST_LO_WAIT: begin
                spi_data_d = cur_word[7:0];
                if (!spi.spi_busy) begin
                    start_d = 1'b1;
                    state_d = ST_LO_SEND;
                end
            end
            // LOAD rises only after the data byte has fully shifted out.
            ST_LO_SEND: begin
                if (spi.spi_avail) begin
                    load_n_d = 1'b1;
                    gap_d    = '0;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (idx_q == last_idx(job_q)) begin
                        idx_d   = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_HI_WAIT;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HI_WAIT;
            job_q      <= JOB_INIT;
            idx_q      <= 3'd0;
            gap_q      <= '0;
            load_n_q   <= 1'b1;
            start_q    <= 1'b0;
            spi_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            job_q      <= job_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            load_n_q   <= load_n_d;
            start_q    <= start_d;
            spi_data_q <= spi_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (frame_cap) begin
            frame_q <= frame_data_i;
        end
        if (int_cap) begin
            int_q <= int_val_i;
        end
    end

endmodule

// File: tb/tb_max7219_word_scheduler.sv
// -----------------------------------------------------------------------------
// tb_max7219_word_scheduler
//   Drives the scheduler's requesters, models a byte-wide spi_master, captures
//   every byte the scheduler launches and compares the stream with the register
//   writes expected for each job. LOAD/CS shape and strobe rules are watched
//   continuously and summarised at the end.
// -----------------------------------------------------------------------------
module tb_max7219_word_scheduler;
    localparam int         LOAD_GAP = 4;
    localparam logic [3:0] INIT_INT = 4'hA;
    localparam logic [2:0] SCAN_LIM = 3'd7;

    logic        clk;
    logic        rst_n;
    logic        frame_req, frame_ack;
    logic [63:0] frame_data;
    logic        int_req, int_ack;
    logic [3:0]  int_val;
    logic        reinit_req;
    logic        load_n, ready;
    logic        force_busy, rand_lat;

    max7219_word_scheduler_if spi_if();

    max7219_word_scheduler #(
        .INIT_INTENSITY (INIT_INT),
        .SCAN_LIMIT     (SCAN_LIM),
        .LOAD_GAP       (LOAD_GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_req_i  (frame_req),
        .frame_data_i (frame_data),
        .frame_ack_o  (frame_ack),
        .int_req_i    (int_req),
        .int_val_i    (int_val),
        .int_ack_o    (int_ack),
        .reinit_req_i (reinit_req),
        .spi          (spi_if),
        .load_n_o     (load_n),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // spi_master model: busy from the start edge, avail with busy release.
    logic model_busy, model_avail;
    int   lat_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_busy  <= 1'b0;
            model_avail <= 1'b0;
            lat_cnt     <= 0;
        end else begin
            model_avail <= 1'b0;
            if (model_busy) begin
                if (lat_cnt <= 1) begin
                    model_busy  <= 1'b0;
                    model_avail <= 1'b1;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end else if (spi_if.spi_start) begin
                model_busy <= 1'b1;
                lat_cnt    <= rand_lat ? int'($urandom_range(25, 2)) : 20;
            end
        end
    end
    assign spi_if.spi_busy  = model_busy | force_busy;
    assign spi_if.spi_avail = model_avail;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state
    logic [7:0] got_bytes[$];
    logic [7:0] exp_bytes[$];
    int n_start = 0, n_fall = 0, n_frame_ack = 0, n_int_ack = 0;
    int viol_consec = 0, viol_busy = 0, viol_shape = 0, viol_gap = 0, viol_outside = 0;
    int hi_run = LOAD_GAP, lo_starts = 0, lo_avails = 0;
    logic prev_start = 1'b0, prev_load = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_start = 1'b0;
                prev_load  = 1'b1;
                hi_run     = LOAD_GAP;
                lo_starts  = 0;
                lo_avails  = 0;
            end else begin
                if (spi_if.spi_start) begin
                    n_start++;
                    got_bytes.push_back(spi_if.spi_data);
                    if (prev_start)       viol_consec++;
                    if (spi_if.spi_busy)  viol_busy++;
                    if (load_n)           viol_outside++;
                end
                if (frame_ack) n_frame_ack++;
                if (int_ack)   n_int_ack++;
                if (prev_load && !load_n) begin
                    n_fall++;
                    if (hi_run < LOAD_GAP) viol_gap++;
                end
                if (!load_n) begin
                    lo_starts += int'(spi_if.spi_start);
                    lo_avails += int'(spi_if.spi_avail);
                end else if (spi_if.spi_avail) begin
                    viol_outside++;
                end
                if (!prev_load && load_n) begin
                    if (lo_starts != 2 || lo_avails != 2) viol_shape++;
                    lo_starts = 0;
                    lo_avails = 0;
                end
                hi_run     = load_n ? hi_run + 1 : 0;
                prev_start = spi_if.spi_start;
                prev_load  = load_n;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: register writes each job must produce, in order.
    function automatic void push_word(input logic [7:0] a, input logic [7:0] d);
        exp_bytes.push_back(a);
        exp_bytes.push_back(d);
    endfunction

    function automatic void push_init();
        push_word(8'h0C, 8'h01);
        push_word(8'h09, 8'h00);
        push_word(8'h0A, {4'h0, INIT_INT});
        push_word(8'h0B, {5'b0, SCAN_LIM});
        push_word(8'h0F, 8'h00);
    endfunction

    function automatic void push_frame(input logic [63:0] d);
        for (int r = 0; r < 8; r++) begin
            push_word(8'(r + 1), d[8*r +: 8]);
        end
    endfunction

    function automatic void push_int(input logic [3:0] v);
        push_word(8'h0A, {4'h0, v});
    endfunction

    task automatic clear_capture();
        got_bytes.delete();
        exp_bytes.delete();
        n_start = 0;
        n_fall  = 0;
    endtask

    task automatic compare_stream(input string tag);
        check_eq({tag, "_nbytes"}, 64'(got_bytes.size()), 64'(exp_bytes.size()));
        for (int i = 0; i + 1 < exp_bytes.size(); i += 2) begin
            logic [15:0] g;
            g = (i + 1 < got_bytes.size()) ? {got_bytes[i], got_bytes[i+1]} : 16'h0000;
            check_eq($sformatf("%s_word%0d", tag, i / 2), 64'(g),
                     64'({exp_bytes[i], exp_bytes[i+1]}));
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ready"}, 64'(ready), 64'd1);
    endtask

    task automatic req_frame(input logic [63:0] d, output int ack_cyc);
        int n = 0;
        frame_data = d;
        frame_req  = 1'b1;
        @(negedge clk);
        while (!frame_ack && n < 4000) begin
            @(negedge clk);
            n++;
        end
        ack_cyc = cyc;
        check_eq("frame_ack", 64'(frame_ack), 64'd1);
        check_eq("frame_ack_in_idle", 64'(ready), 64'd1);
        @(posedge clk);
        #1;
        frame_req  = 1'b0;
        frame_data = {$urandom, $urandom};
        @(negedge clk);
        check_eq("frame_ack_pulse", 64'(frame_ack), 64'd0);
    endtask

    task automatic req_int(input logic [3:0] v, output int ack_cyc);
        int n = 0;
        int_val = v;
        int_req = 1'b1;
        @(negedge clk);
        while (!int_ack && n < 4000) begin
            @(negedge clk);
            n++;
        end
        ack_cyc = cyc;
        check_eq("int_ack", 64'(int_ack), 64'd1);
        @(posedge clk);
        #1;
        int_req = 1'b0;
        int_val = 4'($urandom);
        @(negedge clk);
        check_eq("int_ack_pulse", 64'(int_ack), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [63:0] fd;
    logic [3:0]  iv;
    int          t_i, t_f, fa0, ia0, n, kind, viol;

    initial begin
        rst_n      = 1'b0;
        frame_req  = 1'b1;
        int_req    = 1'b1;
        reinit_req = 1'b0;
        frame_data = 64'h0;
        int_val    = 4'h0;
        force_busy = 1'b0;
        rand_lat   = 1'b0;

        // Reset state, with requests pending to prove acks stay quiet.
        repeat (3) @(negedge clk);
        check_eq("rst_ready",     64'(ready),            64'd0);
        check_eq("rst_load_n",    64'(load_n),           64'd1);
        check_eq("rst_start",     64'(spi_if.spi_start), 64'd0);
        check_eq("rst_spi_data",  64'(spi_if.spi_data),  64'd0);
        check_eq("rst_frame_ack", 64'(frame_ack),        64'd0);
        check_eq("rst_int_ack",   64'(int_ack),          64'd0);
        frame_req = 1'b0;
        int_req   = 1'b0;

        // Power-up init.
        @(posedge clk);
        #1;
        clear_capture();
        push_init();
        rst_n = 1'b1;
        wait_ready("init");
        compare_stream("init");
        check_eq("init_falls",  64'(n_fall),  64'd5);
        check_eq("init_starts", 64'(n_start), 64'd10);

        // Directed frame; frame_data scrambled after ack.
        @(posedge clk);
        #1;
        clear_capture();
        fd = 64'hFF81A581A5998181;
        push_frame(fd);
        req_frame(fd, t_f);
        wait_ready("frame");
        compare_stream("frame");
        check_eq("frame_falls",  64'(n_fall),  64'd8);
        check_eq("frame_starts", 64'(n_start), 64'd16);

        // Simultaneous intensity and frame requests: intensity first.
        @(posedge clk);
        #1;
        clear_capture();
        iv = 4'h5;
        fd = {$urandom, $urandom};
        push_int(iv);
        push_frame(fd);
        fork
            req_int(iv, t_i);
            req_frame(fd, t_f);
        join
        check_eq("both_int_first", 64'(t_i < t_f), 64'd1);
        wait_ready("both");
        compare_stream("both");

        // Re-init raised mid-frame: frame finishes, then init, no acks.
        @(posedge clk);
        #1;
        clear_capture();
        fa0 = n_frame_ack;
        ia0 = n_int_ack;
        fd  = {$urandom, $urandom};
        push_frame(fd);
        req_frame(fd, t_f);
        n = 0;
        while (got_bytes.size() < 6 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        reinit_req = 1'b1;
        n = 0;
        while (!ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check_eq("reinit_frame_done", 64'(got_bytes.size()), 64'd16);
        check_eq("reinit_idle_seen",  64'(ready),            64'd1);
        @(posedge clk);
        #1;
        reinit_req = 1'b0;
        push_init();
        wait_ready("reinit");
        compare_stream("reinit");
        check_eq("reinit_frame_acks", 64'(n_frame_ack - fa0), 64'd1);
        check_eq("reinit_int_acks",   64'(n_int_ack - ia0),   64'd0);

        // spi_busy held high in HI_WAIT: no strobe, LOAD stays high.
        @(posedge clk);
        #1;
        clear_capture();
        force_busy = 1'b1;
        iv = 4'($urandom);
        push_int(iv);
        req_int(iv, t_i);
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (spi_if.spi_start || !load_n) viol++;
        end
        check_eq("busy_hold_quiet",  64'(viol),    64'd0);
        check_eq("busy_hold_starts", 64'(n_start), 64'd0);
        @(posedge clk);
        #1;
        force_busy = 1'b0;
        wait_ready("busy");
        compare_stream("busy");

        // Reset during the data byte of word 3 of init.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_capture();
        rst_n = 1'b1;
        n = 0;
        while (got_bytes.size() < 8 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_reached_word3", 64'(got_bytes.size()), 64'd8);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_load_n", 64'(load_n),           64'd1);
        check_eq("abort_start",  64'(spi_if.spi_start), 64'd0);
        check_eq("abort_ready",  64'(ready),            64'd0);
        repeat (2) @(posedge clk);
        #1;
        clear_capture();
        push_init();
        rst_n = 1'b1;
        wait_ready("restart");
        compare_stream("restart");

        // Randomized jobs with random byte latency.
        rand_lat = 1'b1;
        for (int it = 0; it < 8; it++) begin
            @(posedge clk);
            #1;
            clear_capture();
            kind = int'($urandom_range(2, 0));
            iv   = 4'($urandom);
            fd   = {$urandom, $urandom};
            if (kind == 0) begin
                push_int(iv);
                req_int(iv, t_i);
            end else if (kind == 1) begin
                push_frame(fd);
                req_frame(fd, t_f);
            end else begin
                push_int(iv);
                push_frame(fd);
                fork
                    req_int(iv, t_i);
                    req_frame(fd, t_f);
                join
                check_eq($sformatf("rand%0d_int_first", it), 64'(t_i < t_f), 64'd1);
            end
            wait_ready($sformatf("rand%0d", it));
            compare_stream($sformatf("rand%0d", it));
        end

        check_eq("proto_consec_start", 64'(viol_consec),  64'd0);
        check_eq("proto_start_busy",   64'(viol_busy),    64'd0);
        check_eq("proto_load_shape",   64'(viol_shape),   64'd0);
        check_eq("proto_load_gap",     64'(viol_gap),     64'd0);
        check_eq("proto_outside_word", 64'(viol_outside), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
